// File: rtl/univ_shift_reg.sv
// Universal shift register with a start/count command interface: runs N single-bit
// shift/rotate steps (or one parallel load) autonomously, reporting busy and done.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             sin,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_LOAD = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_t;

    state_t           state;
    state_t           state_next;
    op_t              op_l;
    logic [WIDTH-1:0] din_l;
    logic [CNT_W-1:0] cnt;
    logic             is_step;

    assign is_step = (mode == OP_SHL) || (mode == OP_SHR) ||
                     (mode == OP_ROL) || (mode == OP_ROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (mode == OP_LOAD) begin
                        state_next = RUN;
                    end else if (is_step && (count != '0)) begin
                        state_next = RUN;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath works only from the latched command; live inputs other than sin are ignored in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= '0;
            sout  <= 1'b0;
            cnt   <= '0;
            op_l  <= OP_HOLD;
            din_l <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_l  <= op_t'(mode);
                        din_l <= din;
                        cnt   <= (mode == OP_LOAD) ? CNT_W'(1) : count;
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    case (op_l)
                        OP_SHL: begin
                            out  <= {out[WIDTH-2:0], sin};
                            sout <= out[WIDTH-1];
                        end
                        OP_SHR: begin
                            out  <= {sin, out[WIDTH-1:1]};
                            sout <= out[0];
                        end
                        OP_ROL: begin
                            out  <= {out[WIDTH-2:0], out[WIDTH-1]};
                            sout <= out[WIDTH-1];
                        end
                        OP_ROR: begin
                            out  <= {out[0], out[WIDTH-1:1]};
                            sout <= out[0];
                        end
                        OP_LOAD: out <= din_l;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus random commands
// compared against an arithmetic reference model of the register.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] count;
    logic          sin;
    logic [W-1:0]  din;
    logic [W-1:0]  out;
    logic          sout;
    logic          busy;
    logic          done;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_out  = 0;
    int m_sout = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count),
        .sin(sin), .din(din), .out(out), .sout(sout), .busy(busy), .done(done)
    );

    // Reference: register value as an integer, one step computed with plain arithmetic.
    function automatic void model_step(input int m, input int s, input int d);
        int full;
        int top;
        int b;
        full = 1 << W;
        top  = 1 << (W - 1);
        case (m)
            1: begin m_sout = m_out / top;  m_out = (m_out * 2) % full + s;       end
            2: begin m_sout = m_out % 2;    m_out = m_out / 2 + s * top;         end
            3: begin b = m_out / top; m_sout = b; m_out = (m_out * 2) % full + b; end
            4: begin b = m_out % 2;   m_sout = b; m_out = m_out / 2 + b * top;    end
            5: m_out = d % full;
            default: ;
        endcase
    endfunction

    // Issues one command and checks every cycle until it returns to idle.
    task automatic exec_cmd(input string tag, input int m, input int c, input int d,
                            input int sin_mode, input bit poke);
        int nsteps;
        int s;
        logic [W-1:0] exp_out;
        @(negedge clk);
        start = 1'b1; mode = 3'(m); count = CW'(c); din = W'(d);
        if (m == 5) nsteps = 1;
        else if (m >= 1 && m <= 4) nsteps = c;
        else nsteps = 0;
        @(negedge clk);
        start = 1'b0; mode = 3'($urandom); count = CW'($urandom); din = W'($urandom);
        for (int i = 0; i < nsteps; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s run_status step %0d: busy=%b done=%b, expected busy=1 done=0", tag, i, busy, done);
            end
            s = (sin_mode == 2) ? int'($urandom_range(0, 1)) : sin_mode;
            sin = s[0];
            if (poke && i == 1) begin
                start = 1'b1; mode = 3'd5; din = '1;
            end else begin
                start = 1'b0;
            end
            model_step(m, s, d);
            exp_out = m_out[W-1:0];
            @(negedge clk);
            n_cmp++;
            if (out !== exp_out || sout !== m_sout[0]) begin
                n_fail++;
                $display("FAIL %s step %0d: out=%h sout=%b, expected out=%h sout=%b", tag, i, out, sout, exp_out, m_sout[0]);
            end
        end
        start = 1'b0;
        exp_out = m_out[W-1:0];
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || out !== exp_out || sout !== m_sout[0]) begin
            n_fail++;
            $display("FAIL %s done: done=%b busy=%b out=%h sout=%b, expected done=1 busy=0 out=%h sout=%b",
                     tag, done, busy, out, sout, exp_out, m_sout[0]);
        end
        start = 1'b1; mode = 3'd5; din = ~exp_out;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== exp_out || sout !== m_sout[0]) begin
            n_fail++;
            $display("FAIL %s idle: done=%b busy=%b out=%h sout=%b, expected done=0 busy=0 out=%h sout=%b",
                     tag, done, busy, out, sout, exp_out, m_sout[0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; mode = 3'd5; count = '0; din = 8'hA5; sin = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (out !== 8'h00 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: out=%h sout=%b busy=%b done=%b, expected all zero", out, sout, busy, done);
            end
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_cmd: out=%h busy=%b done=%b, expected 00/0/0", out, busy, done);
        end
        m_out = 0; m_sout = 0;
    endtask

    task automatic test_load();
        exec_cmd("load", 5, 0, 8'hA5, 0, 1'b0);
        n_cmp++;
        if (out !== 8'hA5 || sout !== 1'b0) begin
            n_fail++;
            $display("FAIL load_value: out=%h sout=%b, expected A5/0", out, sout);
        end
    endtask

    task automatic test_shl();
        exec_cmd("shl3", 1, 3, 0, 1, 1'b0);
        n_cmp++;
        if (out !== 8'h2F || sout !== 1'b1) begin
            n_fail++;
            $display("FAIL shl3_value: out=%h sout=%b, expected 2F/1", out, sout);
        end
    endtask

    task automatic test_rotate_chain();
        exec_cmd("ror4", 4, 4, 0, 2, 1'b0);
        n_cmp++;
        if (out !== 8'hF2 || sout !== 1'b1) begin
            n_fail++;
            $display("FAIL ror4_value: out=%h sout=%b, expected F2/1", out, sout);
        end
        exec_cmd("rol8", 3, 8, 0, 2, 1'b0);
        n_cmp++;
        if (out !== 8'hF2) begin
            n_fail++;
            $display("FAIL rol8_value: out=%h, expected F2", out);
        end
        exec_cmd("shr9", 2, 9, 0, 0, 1'b0);
        n_cmp++;
        if (out !== 8'h00) begin
            n_fail++;
            $display("FAIL shr9_value: out=%h, expected 00", out);
        end
    endtask

    task automatic test_ignored();
        exec_cmd("reload", 5, 0, 8'hC3, 0, 1'b0);
        exec_cmd("shr5_poke", 2, 5, 0, 2, 1'b1);
        exec_cmd("count0", 1, 0, 8'h11, 1, 1'b0);
        exec_cmd("hold_mode", 0, 7, 8'h11, 1, 1'b0);
        exec_cmd("mode7", 7, 3, 8'h11, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        exec_cmd("mid_load", 5, 0, 8'h96, 0, 1'b0);
        @(negedge clk);
        start = 1'b1; mode = 3'd3; count = CW'(8);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b, expected 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_out = 0; m_sout = 0;
        n_cmp++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_abort: out=%h busy=%b done=%b sout=%b, expected 00/0/0/0", out, busy, done, sout);
        end
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_quiet: done=%b busy=%b, expected 0/0", done, busy);
            end
        end
        exec_cmd("post_load", 5, 0, 8'h3C, 2, 1'b0);
        exec_cmd("post_shl", 1, 2, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            exec_cmd("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 255)), 2, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shl();
        test_rotate_chain();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
